// File: rtl/loong_dec_iter_if.sv
// ----------------------------------------------------------------------------
// loong_dec_iter_if : ciphertext/key input and plaintext output handshakes
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface loong_dec_iter_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ciphertext [15:0];
  logic [3:0] roundKey   [15:0];
  logic       out_valid;
  logic       out_ready;
  logic [3:0] plaintext  [15:0];
  logic       busy;

  modport master (
    output in_valid, ciphertext, roundKey, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );

  modport slave (
    input  in_valid, ciphertext, roundKey, out_ready,
    output in_ready, out_valid, plaintext, busy
  );
endinterface

`default_nettype wire

// File: rtl/loong_dec_iter.sv
// ----------------------------------------------------------------------------
// loong_dec_iter : iterative LOONG block decryptor, one inverse round per clock
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package loong_pkg;
  localparam logic [3:0] RC [32] = '{
    4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
    4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1,
    4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
    4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Hadamard matrix with entry sum 1 is involutory, so inverse equals forward
  localparam logic [3:0] MIX_INV [4][4] = '{
    '{4'h1, 4'h2, 4'h4, 4'h6},
    '{4'h2, 4'h1, 4'h6, 4'h4},
    '{4'h4, 4'h6, 4'h1, 4'h2},
    '{4'h6, 4'h4, 4'h2, 4'h1}
  };
endpackage

module loong_dec_iter #(
  parameter int NR = 16
) (
  input  logic            clk,
  input  logic            reset,
  loong_dec_iter_if.slave bus
);
  import loong_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [4:0] R_LAST = 5'(NR - 1);

  logic [1:0] state_q, state_d;
  logic [4:0] r_q, r_d;
  logic [3:0] key_q [15:0];
  logic [3:0] key_d [15:0];
  logic [3:0] st_q  [15:0];
  logic [3:0] st_d  [15:0];
  logic [3:0] pt_q  [15:0];
  logic [3:0] pt_d  [15:0];

  logic [3:0] w_ark [15:0];
  logic [3:0] w_mix [15:0];
  logic [3:0] w_shr [15:0];
  logic [3:0] w_rnd [15:0];

  // GF(2^4) multiply, reduction by x^4 = x + 1
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_ark
    if (i == 0) begin : g_rc
      assign w_ark[i] = st_q[i] ^ key_q[i] ^ RC[r_q];
    end else begin : g_key
      assign w_ark[i] = st_q[i] ^ key_q[i];
    end
  end

  // Nibble index is 4*column + row; inverse ShiftRows rotates row i right by i
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar row = 0; row < 4; row++) begin : g_row
      assign w_mix[4*c+row] = gf_mul(MIX_INV[row][0], w_ark[4*c])
                            ^ gf_mul(MIX_INV[row][1], w_ark[4*c+1])
                            ^ gf_mul(MIX_INV[row][2], w_ark[4*c+2])
                            ^ gf_mul(MIX_INV[row][3], w_ark[4*c+3]);
      assign w_shr[4*c+row] = w_mix[4*((c-row+4)%4)+row];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign w_rnd[i] = SBOX_INV[w_shr[i]];
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    key_d   = key_q;
    st_d    = st_q;
    pt_d    = pt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          key_d = bus.roundKey;
          for (int i = 0; i < 16; i++) st_d[i] = bus.ciphertext[i] ^ bus.roundKey[i];
          r_d     = R_LAST;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        st_d = w_rnd;
        if (r_q == 5'd0) begin
          pt_d    = w_rnd;
          state_d = S_DONE;
        end else begin
          r_d = r_q - 5'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      r_q     <= 5'd0;
      for (int i = 0; i < 16; i++) begin
        key_q[i] <= 4'h0;
        st_q[i]  <= 4'h0;
        pt_q[i]  <= 4'h0;
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      key_q   <= key_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.plaintext = pt_q;

endmodule

`default_nettype wire

// File: tb/tb_loong_dec_iter.sv
// ----------------------------------------------------------------------------
// tb_loong_dec_iter : loopback bench, ciphertext built by a reference encryptor
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_loong_dec_iter;
  localparam int NR = 16;

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  localparam logic [3:0] RCT [32] = '{
    4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
    4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1,
    4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
    4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2
  };
  // MixColumns coefficient for (row, col) is HX[row ^ col]
  localparam logic [3:0] HX [4] = '{4'h1, 4'h2, 4'h4, 4'h6};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  loong_dec_iter_if bus();

  loong_dec_iter #(.NR(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int ov_cnt = 0;
  int last_acc = 0;
  int prev_acc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_valid && bus.out_ready) xfer_cnt <= xfer_cnt + 1;
    if (bus.out_valid) ov_cnt <= ov_cnt + 1;
    if (bus.in_valid && bus.in_ready) begin
      last_acc <= cyc;
      prev_acc <= last_acc;
    end
  end

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = 7'h0;
    for (int k = 0; k < 4; k++) if (b[k]) p = p ^ (7'(a) << k);
    for (int k = 6; k >= 4; k--) if (p[k]) p = p ^ (7'h13 << (k - 4));
    return p[3:0];
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] pt, input logic [63:0] key);
    logic [3:0] s [16];
    logic [3:0] t [16];
    logic [3:0] acc;
    logic [63:0] ct;
    for (int i = 0; i < 16; i++) s[i] = pt[4*i +: 4];
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < 16; i++) t[i] = SB[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          acc = 4'h0;
          for (int j = 0; j < 4; j++) acc = acc ^ gmul(HX[row^j], s[4*c+j]);
          t[4*c+row] = acc;
        end
      t[0] = t[0] ^ RCT[r];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ key[4*i +: 4];
    end
    for (int i = 0; i < 16; i++) ct[4*i +: 4] = s[i] ^ key[4*i +: 4];
    return ct;
  endfunction

  function automatic logic [63:0] pt_now();
    logic [63:0] v;
    for (int i = 0; i < 16; i++) v[4*i +: 4] = bus.plaintext[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] ct, input logic [63:0] key);
    for (int i = 0; i < 16; i++) begin
      bus.ciphertext[i] = ct[4*i +: 4];
      bus.roundKey[i]   = key[4*i +: 4];
    end
  endtask

  // Returns just after the accept edge, with the input bus scrambled
  task automatic send(input logic [63:0] ct, input logic [63:0] key);
    int n;
    n = 0;
    while (!bus.in_ready && n < 4*NR) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("send_timeout", 64'(n), 64'(4*NR - 1));
    bus.in_valid = 1'b1;
    drive(ct, key);
    tick();
    bus.in_valid = 1'b0;
    drive({$urandom(), $urandom()}, {$urandom(), $urandom()});
  endtask

  task automatic wait_out(input int lat0, output int lat, output logic [63:0] pt);
    lat = lat0;
    while (!bus.out_valid && lat < 4*NR) begin
      tick();
      lat++;
    end
    pt = pt_now();
  endtask

  typedef struct {
    logic [63:0] ct;
    logic [63:0] key;
    logic [63:0] exp_pt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [63:0] pt, key, got, p0;
    int lat, x0, c0;
    bit stable;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(64'h0, 64'h0);

    vecs[0].exp_pt = 64'h0;                vecs[0].key = 64'h0;
    vecs[1].exp_pt = 64'hFEDCBA9876543210; vecs[1].key = 64'h0123456789ABCDEF;
    vecs[2].exp_pt = 64'hFFFFFFFFFFFFFFFF; vecs[2].key = 64'hFFFFFFFFFFFFFFFF;
    vecs[3].exp_pt = 64'h0123456789ABCDEF; vecs[3].key = 64'h0;
    vecs[4].exp_pt = 64'h0;                vecs[4].key = 64'hA5A55A5A0F0FF0F0;
    for (int v = 0; v < 5; v++) vecs[v].ct = enc(vecs[v].exp_pt, vecs[v].key);

    reset = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_plaintext", pt_now(), 64'h0);
    tick();

    for (int v = 0; v < 5; v++) begin
      send(vecs[v].ct, vecs[v].key);
      if (v == 0) check("run_busy_noready", {62'h0, bus.busy, bus.in_ready}, 64'h2);
      if (v > 0) check("throughput", 64'(last_acc - prev_acc), 64'(NR + 2));
      wait_out(1, lat, got);
      check("vec_latency", 64'(lat), 64'(NR + 1));
      check("vec_plaintext", got, vecs[v].exp_pt);
      tick();
      check("vec_post_xfer", {62'h0, bus.out_valid, bus.in_ready}, 64'h1);
    end

    for (int n = 0; n < 200; n++) begin
      pt  = {$urandom(), $urandom()};
      key = {$urandom(), $urandom()};
      send(enc(pt, key), key);
      wait_out(1, lat, got);
      check("rand_plaintext", got, pt);
      tick();
    end

    pt  = 64'h1357_9BDF_0246_8ACE;
    key = 64'hDEAD_BEEF_CAFE_F00D;
    bus.out_ready = 1'b0;
    send(enc(pt, key), key);
    wait_out(1, lat, got);
    check("bp_plaintext", got, pt);
    p0 = got;
    x0 = xfer_cnt;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!bus.out_valid || pt_now() !== p0) stable = 1'b0;
    end
    check("bp_hold_stable", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_one_xfer", 64'(xfer_cnt - x0), 64'd1);
    check("bp_post_xfer", {62'h0, bus.out_valid, bus.in_ready}, 64'h1);
    check("bp_pt_retained", pt_now(), p0);
    tick();
    check("bp_no_extra_xfer", 64'(xfer_cnt - x0), 64'd1);

    pt  = 64'h0F1E_2D3C_4B5A_6978;
    key = 64'h8877_6655_4433_2211;
    send(enc(pt, key), key);
    repeat (4) tick();
    bus.in_valid = 1'b1;
    drive(64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0);
    check("busy_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    wait_out(6, lat, got);
    check("busy_latency", 64'(lat), 64'(NR + 1));
    check("busy_plaintext", got, pt);
    tick();

    pt  = 64'hFACE_B00C_1234_4321;
    key = 64'h0BAD_F00D_0BAD_F00D;
    send(enc(pt, key), key);
    repeat (7) tick();
    c0 = ov_cnt;
    reset = 1'b0;
    tick();
    check("midrst_state", {61'h0, bus.busy, bus.in_ready, bus.out_valid}, 64'h2);
    check("midrst_plaintext", pt_now(), 64'h0);
    reset = 1'b1;
    repeat (2*NR) tick();
    check("midrst_no_output", 64'(ov_cnt - c0), 64'd0);
    pt  = 64'h5555_AAAA_3333_CCCC;
    key = 64'h9999_6666_1111_EEEE;
    send(enc(pt, key), key);
    wait_out(1, lat, got);
    check("midrst_next_latency", 64'(lat), 64'(NR + 1));
    check("midrst_next_plaintext", got, pt);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
